alu_issue_stage: RTL

Operand issue and result capture stage wrapped around the combinational `alu`. It buffers incoming operation commands `{a, b, ctrl}` in a small FIFO and presents the FIFO head to the ALU. It registers the ALU's `y`/`cout` into a result register with a valid/ready handshake. This makes the purely combinational ALU a 2-cycle, 1-op-per-cycle pipelined unit with back-pressure on both sides.

---
 rtl/alu_issue_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO and result register wrapped around a combinational ALU
// Head of the FIFO drives the ALU; pops capture the ALU output into a valid/ready result register.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   cmd_a,
  input  logic [31:0]   cmd_b,
  input  logic [2:0]    cmd_ctrl,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_ctrl,
  input  logic [31:0]   alu_y,
  input  logic          alu_cout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_y,
  output logic          res_cout,
  output logic [2:0]    res_ctrl,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_y_q, res_y_d;
  logic          res_cout_q, res_cout_d;
  logic [2:0]    res_ctrl_q, res_ctrl_d;
  logic          full, empty, push, pop;

  // Handshake qualifiers depend only on registered state so cmd_ready has no path from cmd_valid.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign pop   = !empty && (!res_valid_q || res_ready);
  assign head  = mem_q[rd_ptr_q];

  assign cmd_ready = !full;
  assign alu_a     = empty ? 32'd0 : head.a;
  assign alu_b     = empty ? 32'd0 : head.b;
  assign alu_ctrl  = empty ? 3'd0  : head.ctrl;
  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_cout  = res_cout_q;
  assign res_ctrl  = res_ctrl_q;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_cout_d  = res_cout_q;
    res_ctrl_d  = res_ctrl_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Data fields keep their last value when the register simply drains.
    if (pop) begin
      res_valid_d = 1'b1;
      res_y_d     = alu_y;
      res_cout_d  = alu_cout;
      res_ctrl_d  = head.ctrl;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_cout_q  <= 1'b0;
      res_ctrl_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_cout_q  <= res_cout_d;
      res_ctrl_q  <= res_ctrl_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, ctrl: cmd_ctrl};
  end

endmodule
